// File: rtl/uart_istek_hakemi.sv
// Two-requester round-robin arbiter in front of the UART controller's request/response port.
// Optional read-response timeout is enabled by defining UART_HAKEM_ZAMAN_ASIMI_EN.
module uart_istek_hakemi #(
  parameter int ADRES_BIT   = 32,
  parameter int VERI_BIT    = 32,
  parameter int ZAMAN_ASIMI = 255
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,

  input  logic [ADRES_BIT-1:0] istek0_adres_i,
  input  logic [VERI_BIT-1:0]  istek0_veri_i,
  input  logic                 istek0_yaz_i,
  input  logic                 istek0_gecerli_i,
  output logic                 istek0_hazir_o,
  output logic [VERI_BIT-1:0]  yanit0_veri_o,
  output logic                 yanit0_gecerli_o,
  input  logic                 yanit0_hazir_i,

  input  logic [ADRES_BIT-1:0] istek1_adres_i,
  input  logic [VERI_BIT-1:0]  istek1_veri_i,
  input  logic                 istek1_yaz_i,
  input  logic                 istek1_gecerli_i,
  output logic                 istek1_hazir_o,
  output logic [VERI_BIT-1:0]  yanit1_veri_o,
  output logic                 yanit1_gecerli_o,
  input  logic                 yanit1_hazir_i,

  output logic [ADRES_BIT-1:0] cek_adres_o,
  output logic [VERI_BIT-1:0]  cek_veri_o,
  output logic                 cek_yaz_o,
  output logic                 cek_gecerli_o,
  input  logic                 cek_hazir_i,

  input  logic [VERI_BIT-1:0]  uart_veri_i,
  input  logic                 uart_gecerli_i,
  output logic                 uart_hazir_o
);

  typedef enum logic [1:0] {
    BOSTA       = 2'd0,
    ISTEK       = 2'd1,
    YANIT_BEKLE = 2'd2
  } durum_t;

  localparam logic [31:0] ZAMAN_ASIMI_VERI = 32'hDEAD_BEEF;

  durum_t              durum_r;
  logic                oncelik_r;
  logic                sahip_r;

  logic                sec1;
  logic                bekle;
  logic                sahip_hazir;
  logic                zaman_doldu;
  logic                yanit_gecerli;
  logic [VERI_BIT-1:0] yanit_veri;

`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
  localparam int SAYAC_BIT = ($clog2(ZAMAN_ASIMI + 1) > 8) ? $clog2(ZAMAN_ASIMI + 1) : 8;
  logic [SAYAC_BIT-1:0] sayac_r;

  always_comb begin
    zaman_doldu = (durum_r == YANIT_BEKLE) && (sayac_r == SAYAC_BIT'(ZAMAN_ASIMI));
  end
`else
  always_comb begin
    zaman_doldu = 1'b0;
  end
`endif

  // Requester 1 wins when it is the only one asking, or when both ask and it holds priority.
  always_comb begin
    sec1 = istek1_gecerli_i && (!istek0_gecerli_i || oncelik_r);
  end

  // Once the timeout fires the synthetic response replaces the UART one, which is then swallowed.
  always_comb begin
    yanit_gecerli = uart_gecerli_i;
    yanit_veri    = uart_veri_i;
    if (zaman_doldu) begin
      yanit_gecerli = 1'b1;
      yanit_veri    = VERI_BIT'(ZAMAN_ASIMI_VERI);
    end
  end

  // Handshake-side outputs are gated by rstn_i so they read 0 the moment reset asserts.
  always_comb begin
    bekle            = (durum_r == YANIT_BEKLE);
    sahip_hazir      = sahip_r ? yanit1_hazir_i : yanit0_hazir_i;

    istek0_hazir_o   = rstn_i && (durum_r == BOSTA) && istek0_gecerli_i && !sec1;
    istek1_hazir_o   = rstn_i && (durum_r == BOSTA) && sec1;

    yanit0_gecerli_o = bekle && !sahip_r && yanit_gecerli;
    yanit1_gecerli_o = bekle &&  sahip_r && yanit_gecerli;
    yanit0_veri_o    = (bekle && !sahip_r) ? yanit_veri : '0;
    yanit1_veri_o    = (bekle &&  sahip_r) ? yanit_veri : '0;

    uart_hazir_o     = rstn_i && (bekle ? (zaman_doldu || sahip_hazir) : 1'b1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_r       <= BOSTA;
      oncelik_r     <= 1'b0;
      sahip_r       <= 1'b0;
      cek_adres_o   <= '0;
      cek_veri_o    <= '0;
      cek_yaz_o     <= 1'b0;
      cek_gecerli_o <= 1'b0;
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
      sayac_r       <= '0;
`endif
    end else begin
      case (durum_r)
        BOSTA: begin
          if (istek0_gecerli_i || istek1_gecerli_i) begin
            sahip_r       <= sec1;
            cek_adres_o   <= sec1 ? istek1_adres_i : istek0_adres_i;
            cek_veri_o    <= sec1 ? istek1_veri_i  : istek0_veri_i;
            cek_yaz_o     <= sec1 ? istek1_yaz_i   : istek0_yaz_i;
            cek_gecerli_o <= 1'b1;
            durum_r       <= ISTEK;
          end
        end
        ISTEK: begin
          if (cek_hazir_i) begin
            cek_gecerli_o <= 1'b0;
            if (cek_yaz_o) begin
              oncelik_r <= ~sahip_r;
              durum_r   <= BOSTA;
            end else begin
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
              sayac_r   <= '0;
`endif
              durum_r   <= YANIT_BEKLE;
            end
          end
        end
        YANIT_BEKLE: begin
`ifdef UART_HAKEM_ZAMAN_ASIMI_EN
          if (!zaman_doldu) begin
            sayac_r <= sayac_r + 1'b1;
          end
`endif
          if (yanit_gecerli && sahip_hazir) begin
            oncelik_r <= ~sahip_r;
            durum_r   <= BOSTA;
          end
        end
        default: begin
          durum_r <= BOSTA;
        end
      endcase
    end
  end

endmodule
